// File: rtl/matmul_pkg.sv
// Shared defaults, FSM state type and index-width helper for the matrix-multiply sequencer.
// Consumed by matmul_seq_ctrl and matmul_mac.
package matmul_pkg;

  localparam int DIM_DEF   = 4;
  localparam int DW_DEF    = 16;
  localparam int ACC_W_DEF = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_COMPUTE = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // Width of every loop index and element counter; kept at least 1 bit for DIM=1.
  function automatic int idx_w(input int dim);
    return (dim * dim > 1) ? $clog2(dim * dim) : 1;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Single unsigned multiply-accumulate; acc is the combinational result for this cycle's operands.
// acc registers on en; clear restarts the sum from the current product; wraps modulo 2^ACC_W.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] acc_q;

  assign prod = a * b;
  assign acc  = (clear ? '0 : acc_q) + ACC_W'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequential DIM x DIM matrix multiply: loads A then B, computes C with one MAC over DIM^3 cycles, drains C row-major.
// in_ready only while loading; out_data/out_last hold while out_ready is low; done pulses after the last C beat.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int DIM   = DIM_DEF,
  parameter int DW    = DW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int IW = idx_w(DIM);
  localparam int NE = DIM * DIM;
  localparam logic [IW-1:0] LAST_EL = IW'(NE - 1);
  localparam logic [IW-1:0] LAST_IX = IW'(DIM - 1);

  state_t state;
  logic [IW-1:0] ld_cnt, dr_cnt, i_idx, j_idx, k_idx;
  logic [IW-1:0] a_addr, b_addr, c_addr;
  logic [DW-1:0]    a_mem [NE];
  logic [DW-1:0]    b_mem [NE];
  logic [ACC_W-1:0] c_mem [NE];
  logic             in_fire, out_fire, mac_en, mac_clear;
  logic [ACC_W-1:0] mac_acc;

  assign in_ready  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == ST_DRAIN);
  assign out_fire  = out_valid && out_ready;
  assign out_last  = out_valid && (dr_cnt == LAST_EL);
  // Gated by state so storage contents never reach the port outside DRAIN.
  assign out_data  = out_valid ? c_mem[dr_cnt] : '0;
  assign busy      = (state != ST_IDLE);

  assign mac_en    = (state == ST_COMPUTE);
  assign mac_clear = (k_idx == '0);
  assign a_addr    = IW'(int'(i_idx) * DIM + int'(k_idx));
  assign b_addr    = IW'(int'(k_idx) * DIM + int'(j_idx));
  assign c_addr    = IW'(int'(i_idx) * DIM + int'(j_idx));

  matmul_mac #(.DW(DW), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clear (mac_clear),
    .en    (mac_en),
    .a     (a_mem[a_addr]),
    .b     (b_mem[b_addr]),
    .acc   (mac_acc)
  );

  always_ff @(posedge clk) begin
    if (in_fire && (state == ST_LOAD_A)) a_mem[ld_cnt] <= in_data;
    if (in_fire && (state == ST_LOAD_B)) b_mem[ld_cnt] <= in_data;
    if (mac_en && (k_idx == LAST_IX))    c_mem[c_addr] <= mac_acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      ld_cnt <= '0;
      dr_cnt <= '0;
      i_idx  <= '0;
      j_idx  <= '0;
      k_idx  <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_LOAD_A;
        end
        ST_LOAD_A, ST_LOAD_B: begin
          if (in_fire) begin
            if (ld_cnt == LAST_EL) begin
              ld_cnt <= '0;
              state  <= (state == ST_LOAD_A) ? ST_LOAD_B : ST_COMPUTE;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          // k innermost, then j, then i: exactly DIM^3 cycles.
          if (k_idx == LAST_IX) begin
            k_idx <= '0;
            if (j_idx == LAST_IX) begin
              j_idx <= '0;
              if (i_idx == LAST_IX) begin
                i_idx <= '0;
                state <= ST_DRAIN;
              end else begin
                i_idx <= i_idx + 1'b1;
              end
            end else begin
              j_idx <= j_idx + 1'b1;
            end
          end else begin
            k_idx <= k_idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (out_fire) begin
            if (dr_cnt == LAST_EL) begin
              dr_cnt <= '0;
              state  <= ST_IDLE;
              done   <= 1'b1;
            end else begin
              dr_cnt <= dr_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench: random and directed jobs compared against a plain-arithmetic matrix product.
module tb_matmul_seq_ctrl;

  localparam int N  = 4;
  localparam int NN = N * N;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last, busy, done;
  logic [31:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] a_m   [NN];
  logic [15:0] b_m   [NN];
  logic [31:0] c_exp [NN];

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.DIM(N), .DW(16), .ACC_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void build_model();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [63:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s += 64'(a_m[i*N+k]) * 64'(b_m[k*N+j]);
        c_exp[i*N+j] = s[31:0];
      end
    end
  endfunction

  task automatic set_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_m[r*N+c] = (r == c) ? 16'd1 : 16'd0;
        b_m[r*N+c] = 16'(4*r + c + 1);
      end
  endtask

  task automatic set_const(input logic [15:0] v);
    for (int e = 0; e < NN; e++) begin
      a_m[e] = v;
      b_m[e] = v;
    end
  endtask

  task automatic set_random();
    for (int e = 0; e < NN; e++) begin
      a_m[e] = 16'($urandom);
      b_m[e] = 16'($urandom);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"},      busy,      0);
    check_val({tag, "_in_ready"},  in_ready,  0);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_last"},  out_last,  0);
    check_val({tag, "_out_data"},  out_data,  0);
    check_val({tag, "_done"},      done,      0);
  endtask

  // gap_mode: 0 none, 1 drop every third cycle, 2 random. rdy_mode: 0 always, 1 pattern 1-0-0-1, 2 random.
  task automatic run_job(input int gap_mode, input int rdy_mode, input bit poke_start, input bit abort);
    int idx, cyc, cnt, e;
    logic [31:0] held;
    logic        held_last;
    bit          stalled;
    build_model();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD;
    @(negedge clk);
    start = 1'b0;
    check_val("start_busy", busy, 1);
    check_val("load_in_ready", in_ready, 1);

    idx = 0; cyc = 0;
    while (idx < 2*NN && cyc < 500) begin
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 3 != 2);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      in_data = (idx < NN) ? a_m[idx] : b_m[idx-NN];
      start   = poke_start && (idx == NN + 3);
      if (in_valid && in_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    check_val("load_count", idx, 2*NN);
    start    = 1'b0;
    in_valid = poke_start;
    in_data  = 16'hBEEF;

    cnt = 0;
    while (!out_valid && cnt < 300) begin
      if (cnt == 0) check_val("compute_in_ready", in_ready, 0);
      if (abort && cnt == 30) begin
        rst = 1'b1;
        #1;
        check_val("abort_busy", busy, 0);
        check_val("abort_out_valid", out_valid, 0);
        check_val("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("post_abort");
        return;
      end
      cnt++;
      @(negedge clk);
    end
    check_val("compute_cycles", cnt, 64);
    in_valid = 1'b0;

    e = 0; cyc = 0; stalled = 0; held = '0; held_last = 1'b0;
    while (e < NN && cyc < 500) begin
      check_val("drain_valid", out_valid, 1);
      check_val("drain_done_low", done, 0);
      if (stalled) begin
        check_val("hold_data", out_data, held);
        check_val("hold_last", out_last, held_last);
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !((cyc % 4 == 1) || (cyc % 4 == 2));
        default: out_ready = $urandom_range(0, 1) != 0;
      endcase
      start = poke_start && (e == 5);
      if (out_valid && out_ready) begin
        check_val($sformatf("c_%0d", e), out_data, c_exp[e]);
        check_val($sformatf("last_%0d", e), out_last, (e == NN-1));
        e++;
        stalled = 0;
      end else begin
        stalled   = 1;
        held      = out_data;
        held_last = out_last;
      end
      cyc++;
      @(negedge clk);
    end
    check_val("drain_count", e, NN);
    out_ready = 1'b0;
    start     = 1'b0;
    check_val("done_pulse", done, 1);
    check_val("end_busy", busy, 0);
    check_val("end_out_valid", out_valid, 0);
    @(negedge clk);
    check_val("done_single", done, 0);
    check_val("idle_busy", busy, 0);
  endtask

  initial begin
    #12;
    check_idle("in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");

    set_identity();       run_job(0, 0, 0, 0);
    set_const(16'hFFFF);  run_job(0, 0, 0, 0);
    check_val("wrap_model", c_exp[0], 32'hFFF80004);
    set_identity();       run_job(0, 1, 0, 0);
    set_identity();       run_job(1, 0, 0, 0);
    set_random();         run_job(0, 0, 0, 1);
    set_identity();       run_job(0, 0, 0, 0);
    set_random();         run_job(2, 2, 1, 0);
    set_random();         run_job(2, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
